// File: rtl/gs_avg_pkg.sv
// ---------------------------------------------------------------------------
// gs_avg_pkg
// Shared constants, the FSM state type and a small helper for the coherent
// averaging stage of the PEATC raw-signal path.
//   SAMPLES  : samples per sweep (256, addressed with ADDR_W bits)
//   MAX_LOG2 : largest sweep-count exponent accepted (2^8 sweeps)
//   ACC_W    : accumulator width, wide enough that 2^MAX_LOG2 full-scale
//              16-bit samples never overflow
//   CNT_W    : sweep counter width, one bit more than MAX_LOG2 so that the
//              terminal count 2^MAX_LOG2 is representable
// ---------------------------------------------------------------------------
package gs_avg_pkg;

  localparam int SAMPLES  = 256;
  localparam int ADDR_W   = 8;
  localparam int MAX_LOG2 = 8;
  localparam int ACC_W    = 16 + MAX_LOG2;
  localparam int CNT_W    = MAX_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } avgState_e;

  // Requested exponents beyond what the accumulator can hold are treated
  // as the maximum rather than rejected.
  function automatic logic [3:0] clampLog2(input logic [3:0] req);
    return (req > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : req;
  endfunction

endpackage

// File: rtl/gs_epoch_averager_if.sv
// ---------------------------------------------------------------------------
// gs_epoch_averager_if
// Bundles the control, raw-sample and TX-FIFO signals of the epoch averager.
//   iStart, i4SweepsLog2            : run request and sweep-count exponent
//   iSampleValid, iSweepStart,
//   i16Sample                       : raw-signal stream (no backpressure)
//   oFifoWriteEn, o16FifoData,
//   iFifoFull                       : GS FPGA-to-host FIFO write side
//   oBusy, oDone, oSyncErr,
//   o8SweepCount                    : status
// master : the side driving the run/sample/FIFO-full inputs
// slave  : the averager itself
// ---------------------------------------------------------------------------
interface gs_epoch_averager_if;

  logic        iStart;
  logic [3:0]  i4SweepsLog2;
  logic        iSampleValid;
  logic        iSweepStart;
  logic [15:0] i16Sample;
  logic        oFifoWriteEn;
  logic [15:0] o16FifoData;
  logic        iFifoFull;
  logic        oBusy;
  logic        oDone;
  logic        oSyncErr;
  logic [7:0]  o8SweepCount;

  modport master (
    output iStart, i4SweepsLog2, iSampleValid, iSweepStart, i16Sample,
           iFifoFull,
    input  oFifoWriteEn, o16FifoData, oBusy, oDone, oSyncErr, o8SweepCount
  );

  modport slave (
    input  iStart, i4SweepsLog2, iSampleValid, iSweepStart, i16Sample,
           iFifoFull,
    output oFifoWriteEn, o16FifoData, oBusy, oDone, oSyncErr, o8SweepCount
  );

endinterface

// File: rtl/gs_acc_ram.sv
// ---------------------------------------------------------------------------
// gs_acc_ram
// SAMPLES x ACC_W accumulator memory, one synchronous write port and one
// asynchronous read port. The asynchronous read lets the averager do a
// read-modify-write of the same location in a single cycle.
//   iClk        : clock
//   writeEn_i   : write strobe
//   writeAddr_i : write address
//   writeData_i : write data
//   readAddr_i  : read address
//   readData_o  : read data (combinational)
// Contents are not reset; the first sweep of every run overwrites them.
// ---------------------------------------------------------------------------
module gs_acc_ram
  import gs_avg_pkg::*;
(
  input  logic              iClk,
  input  logic              writeEn_i,
  input  logic [ADDR_W-1:0] writeAddr_i,
  input  logic [ACC_W-1:0]  writeData_i,
  input  logic [ADDR_W-1:0] readAddr_i,
  output logic [ACC_W-1:0]  readData_o
);

  logic [ACC_W-1:0] mem [SAMPLES];

  // Plain write port, no reset so it maps onto distributed RAM.
  always_ff @(posedge iClk) begin
    if (writeEn_i) begin
      mem[writeAddr_i] <= writeData_i;
    end
  end

  assign readData_o = mem[readAddr_i];

endmodule

// File: rtl/gs_epoch_averager.sv
// ---------------------------------------------------------------------------
// gs_epoch_averager
// Coherent averaging of 2^n consecutive 256-sample sweeps. Samples are
// summed point by point into gs_acc_ram, then the 256 sums are divided by
// 2^n (arithmetic shift, floor toward -inf) and streamed to the TX FIFO.
//   iClk   : bus_clk
//   iReset : asynchronous, active-high reset
//   bus    : gs_epoch_averager_if slave (run control, samples, FIFO, status)
// ---------------------------------------------------------------------------
module gs_epoch_averager
  import gs_avg_pkg::*;
(
  input  logic               iClk,
  input  logic               iReset,
  gs_epoch_averager_if.slave bus
);

  avgState_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  sweepCnt_q, sweepCnt_d;
  logic [3:0]        log2_q, log2_d;
  logic              syncErr_q, syncErr_d;

  logic              ramWe;
  logic [ACC_W-1:0]  ramWdata;
  logic [ACC_W-1:0]  ramRdata;
  logic [ACC_W-1:0]  sampleExt;
  logic [CNT_W-1:0]  sweepTarget;
  logic [CNT_W-1:0]  sweepCntInc;
  logic [15:0]       drainData;
  logic              lastIdx;

  logic              fifoWe;
  logic [15:0]       fifoData;
  logic              busy;
  logic              done;

  gs_acc_ram accRam (
    .iClk        (iClk),
    .writeEn_i   (ramWe),
    .writeAddr_i (idx_q),
    .writeData_i (ramWdata),
    .readAddr_i  (idx_q),
    .readData_o  (ramRdata)
  );

  assign sampleExt   = {{(ACC_W-16){bus.i16Sample[15]}}, bus.i16Sample};
  assign sweepTarget = CNT_W'(1) << log2_q;
  assign sweepCntInc = sweepCnt_q + CNT_W'(1);
  assign lastIdx     = (idx_q == ADDR_W'(SAMPLES - 1));

  // The shift is done at full accumulator width so the sign bit is
  // replicated correctly before truncating to the 16-bit output.
  assign drainData   = 16'($signed(ramRdata) >>> log2_q);

  // State, index, sweep counter, exponent and sticky error registers.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      sweepCnt_q <= '0;
      log2_q     <= '0;
      syncErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sweepCnt_q <= sweepCnt_d;
      log2_q     <= log2_d;
      syncErr_q  <= syncErr_d;
    end
  end

  // Next-state and output logic. In ACCUM, index 0 only accepts a sample
  // that carries iSweepStart, which re-aligns to the producer; a sweep
  // start seen anywhere else means the stream slipped, so the run aborts
  // without touching the FIFO. The FIFO write enable is combinational on
  // iFifoFull so no write can land while the FIFO is full.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sweepCnt_d = sweepCnt_q;
    log2_d     = log2_q;
    syncErr_d  = syncErr_q;
    ramWe      = 1'b0;
    ramWdata   = sampleExt;
    fifoWe     = 1'b0;
    fifoData   = 16'h0000;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          log2_d     = clampLog2(bus.i4SweepsLog2);
          idx_d      = '0;
          sweepCnt_d = '0;
          syncErr_d  = 1'b0;
          state_d    = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        busy = 1'b1;
        if (bus.iSampleValid) begin
          if (bus.iSweepStart && (idx_q != '0)) begin
            syncErr_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (bus.iSweepStart || (idx_q != '0)) begin
            ramWe    = 1'b1;
            ramWdata = (sweepCnt_q == '0) ? sampleExt : (ramRdata + sampleExt);
            idx_d    = idx_q + ADDR_W'(1);
            if (lastIdx) begin
              sweepCnt_d = sweepCntInc;
              if (sweepCntInc == sweepTarget) begin
                state_d = ST_DRAIN;
              end
            end
          end
        end
      end

      ST_DRAIN: begin
        busy     = 1'b1;
        fifoData = drainData;
        if (!bus.iFifoFull) begin
          fifoWe = 1'b1;
          idx_d  = idx_q + ADDR_W'(1);
          if (lastIdx) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.oFifoWriteEn = fifoWe;
  assign bus.o16FifoData  = fifoData;
  assign bus.oBusy        = busy;
  assign bus.oDone        = done;
  assign bus.oSyncErr     = syncErr_q;
  assign bus.o8SweepCount = sweepCnt_q[7:0];

endmodule

// File: tb/tb_gs_epoch_averager.sv
// ---------------------------------------------------------------------------
// tb_gs_epoch_averager
// Self-checking bench for gs_epoch_averager. A table of runs (exponent,
// sweep pattern, FIFO backpressure, expected sweep count) is applied in a
// loop; a reference model computes the floored averages, which are queued
// when the sweeps are driven and popped by a FIFO-side monitor. Sync-error
// abort and reset during drain are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_gs_epoch_averager;
  import gs_avg_pkg::*;

  typedef struct {
    logic [3:0] log2In;
    int         nEff;
    int         pattern;       // 0: ramp k, 1: constant v[sweep%4], 2: random
    int         v[4];
    bit         backpressure;
    int         expCount;
  } runVec_t;

  logic iClk = 1'b0;
  logic iReset;

  int checks     = 0;
  int errors     = 0;
  int writeCount = 0;
  int expQ[$];
  int modelAcc[SAMPLES];
  int expVal;
  runVec_t vecs[5];

  gs_epoch_averager_if bus();

  gs_epoch_averager dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus.slave)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int floorDiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // FIFO-side monitor: every write must be legal and match the model.
  always @(negedge iClk) begin
    if (bus.oFifoWriteEn === 1'b1) begin
      checkOutput("writeWhileFull", int'(bus.iFifoFull), 0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWrite: data %0d with no expected value queued",
                 $signed(bus.o16FifoData));
      end else begin
        expVal = expQ.pop_front();
        checkOutput("fifoData", int'($signed(bus.o16FifoData)), expVal);
      end
      writeCount++;
    end
  end

  // Drive one cycle of sample inputs, then move to 1 ns after the edge.
  task automatic applyStimulus(input logic valid, input logic sweepStart, input logic [15:0] sample);
    bus.iSampleValid = valid;
    bus.iSweepStart  = sweepStart;
    bus.i16Sample    = sample;
    @(posedge iClk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".writeEn"},    int'(bus.oFifoWriteEn), 0);
    checkOutput({tag, ".data"},       int'(bus.o16FifoData), 0);
    checkOutput({tag, ".busy"},       int'(bus.oBusy), 0);
    checkOutput({tag, ".done"},       int'(bus.oDone), 0);
    checkOutput({tag, ".syncErr"},    int'(bus.oSyncErr), 0);
    checkOutput({tag, ".sweepCount"}, int'(bus.o8SweepCount), 0);
  endtask

  // Start pulse with a simultaneous sample that must be discarded.
  task automatic applyStart(input logic [3:0] log2In);
    bus.iStart       = 1'b1;
    bus.i4SweepsLog2 = log2In;
    bus.iSampleValid = 1'b1;
    bus.iSweepStart  = 1'b1;
    bus.i16Sample    = 16'h1234;
    @(posedge iClk);
    #1;
    bus.iStart       = 1'b0;
    bus.iSampleValid = 1'b0;
    bus.iSweepStart  = 1'b0;
    checkOutput("busyAfterStart", int'(bus.oBusy), 1);
    checkOutput("syncErrAfterStart", int'(bus.oSyncErr), 0);
  endtask

  // Feed 2^n sweeps (preceded by one stray sample that must be dropped),
  // optionally aborting with a misplaced sweep start.
  task automatic feedSweeps(input runVec_t rv, input int abortSweep, input int abortIdx);
    int nSweeps;
    logic [15:0] smp;
    nSweeps = 1 << rv.nEff;
    applyStimulus(1'b1, 1'b0, 16'h7fff);
    for (int s = 0; s < nSweeps; s++) begin
      for (int k = 0; k < SAMPLES; k++) begin
        case (rv.pattern)
          0:       smp = 16'(k);
          1:       smp = 16'(rv.v[s % 4]);
          default: smp = 16'($urandom);
        endcase
        if (s == abortSweep && k == abortIdx) begin
          applyStimulus(1'b1, 1'b1, smp);
          bus.iSampleValid = 1'b0;
          bus.iSweepStart  = 1'b0;
          return;
        end
        if (s == 0) modelAcc[k] = int'($signed(smp));
        else        modelAcc[k] = modelAcc[k] + int'($signed(smp));
        applyStimulus(1'b1, (k == 0), smp);
      end
    end
    bus.iSampleValid = 1'b0;
    bus.iSweepStart  = 1'b0;
    for (int k = 0; k < SAMPLES; k++) begin
      expQ.push_back(floorDiv(modelAcc[k], 1 << rv.nEff));
    end
  endtask

  // Entered on the first DRAIN cycle; runs the drain to completion.
  task automatic drainAndCheck(input runVec_t rv, input int base);
    int cycles;
    bit fullPhase;
    bit gotDone;
    cycles    = 0;
    fullPhase = 1'b0;
    gotDone   = 1'b0;
    checkOutput("sweepCountAtDrain", int'(bus.o8SweepCount), rv.expCount);
    checkOutput("busyAtDrain", int'(bus.oBusy), 1);
    while (!gotDone && cycles < 2000) begin
      if (bus.oDone === 1'b1) begin
        gotDone = 1'b1;
      end else begin
        bus.iFifoFull = rv.backpressure ? fullPhase : 1'b0;
        fullPhase     = ~fullPhase;
        cycles++;
        @(posedge iClk);
        #1;
      end
    end
    bus.iFifoFull = 1'b0;
    if (!gotDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: no done after %0d cycles, required within 2000", cycles);
    end
    checkOutput("busyAtDone", int'(bus.oBusy), 0);
    checkOutput("writesPerRun", writeCount - base, SAMPLES);
    checkOutput("queueEmpty", expQ.size(), 0);
    if (rv.backpressure) begin
      checks++;
      if (cycles < 511 || cycles > 512) begin
        errors++;
        $display("[TB] FAIL drainCyclesBp: got %0d, required 511..512", cycles);
      end
    end else begin
      checkOutput("drainCycles", cycles, SAMPLES);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("donePulseEnd", int'(bus.oDone), 0);
  endtask

  initial begin
    int base;
    int cycles;

    vecs[0] = '{4'd0,  0, 0, '{0, 0, 0, 0},            1'b0, 1};
    vecs[1] = '{4'd2,  2, 1, '{100, 200, -300, 1200},  1'b0, 4};
    vecs[2] = '{4'd1,  1, 1, '{-1, -2, 0, 0},          1'b0, 2};
    vecs[3] = '{4'd2,  2, 1, '{100, 200, -300, 1200},  1'b1, 4};
    vecs[4] = '{4'd12, 8, 2, '{0, 0, 0, 0},            1'b0, 0};

    iReset           = 1'b1;
    bus.iStart       = 1'b0;
    bus.i4SweepsLog2 = 4'd0;
    bus.iSampleValid = 1'b0;
    bus.iSweepStart  = 1'b0;
    bus.i16Sample    = 16'h0000;
    bus.iFifoFull    = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checkAllZero("reset");
    iReset = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000);

    // Sync error: misplaced sweep start at index 37 of the third sweep.
    $display("[TB] sync error sequence");
    applyStart(4'd2);
    base = writeCount;
    feedSweeps(vecs[1], 2, 37);
    checkOutput("syncErrSet", int'(bus.oSyncErr), 1);
    checkOutput("busyAfterSyncErr", int'(bus.oBusy), 0);
    repeat (5) applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("syncErrSticky", int'(bus.oSyncErr), 1);
    checkOutput("syncErrNoWrites", writeCount - base, 0);

    // Restart clears the error; then reset in the middle of the drain.
    $display("[TB] reset during drain sequence");
    applyStart(4'd0);
    base = writeCount;
    feedSweeps(vecs[0], -1, 0);
    cycles = 0;
    while ((writeCount - base) < 100 && cycles < 1000) begin
      @(posedge iClk);
      #1;
      cycles++;
    end
    if ((writeCount - base) < 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainProgress: got %0d writes, required 100", writeCount - base);
    end
    iReset = 1'b1;
    #1;
    checkAllZero("midDrainReset");
    @(posedge iClk);
    #1;
    iReset = 1'b0;
    expQ.delete();
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("noWritesAfterReset", writeCount - base, 100);
    checkOutput("idleAfterReset", int'(bus.oBusy), 0);

    // Table-driven runs: ramp, four sweeps, negative floor, backpressure, clamp.
    for (int r = 0; r < 5; r++) begin
      $display("[TB] run %0d: log2In=%0d", r, vecs[r].log2In);
      applyStart(vecs[r].log2In);
      base = writeCount;
      feedSweeps(vecs[r], -1, 0);
      drainAndCheck(vecs[r], base);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
